// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit holding the architectural HI/LO pair.
// Works on operand magnitudes (shift-add multiply, restoring divide) and fixes signs in a final cycle.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_accHi;
    logic [WIDTH-1:0]   r_accLo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_srcA;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divZeroPulse;

    logic               w_accept;
    logic               w_startIter;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_signed;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_remNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    always_comb begin
        w_accept    = (r_state == IDLE) && start && !flush;
        w_startIter = w_accept && (op[2] == 1'b0);
        w_mthi      = w_accept && (op == 3'b100);
        w_mtlo      = w_accept && (op == 3'b101);
        w_signed    = !op[0];
        w_aNeg      = w_signed && src_a[WIDTH-1];
        w_bNeg      = w_signed && src_b[WIDTH-1];
        w_absA      = w_aNeg ? (-src_a) : src_a;
        w_absB      = w_bNeg ? (-src_b) : src_b;
    end

    // One multiply step adds the multiplicand into the upper half, one divide step
    // shifts the next dividend bit into the partial remainder and tries a subtract.
    always_comb begin
        w_sum     = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shift   = {r_accHi, r_accLo[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_opnd});
        w_remNext = w_ge ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];
        w_prod    = {r_accHi, r_accLo};
        w_prodFix = r_negRes ? (-w_prod) : w_prod;
    end

    always_comb begin
        w_fixHi = w_prodFix[2*WIDTH-1:WIDTH];
        w_fixLo = w_prodFix[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_fixHi = r_srcA;
                w_fixLo = {WIDTH{1'b1}};
            end else begin
                w_fixHi = r_negRem ? (-r_accHi) : r_accHi;
                w_fixLo = r_negRes ? (-r_accLo) : r_accLo;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startIter) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    w_nextState = IDLE;
                end else if (r_count == LAST_STEP) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Multiply: accLo holds the multiplier, opnd the multiplicand.
    // Divide: accLo holds the dividend (becoming the quotient), opnd the divisor.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_opnd    <= '0;
            r_srcA    <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_startIter) begin
            r_count   <= '0;
            r_accHi   <= '0;
            r_accLo   <= op[1] ? w_absA : w_absB;
            r_opnd    <= op[1] ? w_absB : w_absA;
            r_srcA    <= src_a;
            r_isDiv   <= op[1];
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_divZero <= op[1] && (src_b == '0);
        end else if ((r_state == CALC) && !flush) begin
            r_count <= r_count + 1'b1;
            if (r_isDiv) begin
                r_accHi <= w_remNext;
                r_accLo <= {r_accLo[WIDTH-2:0], w_ge};
            end else begin
                {r_accHi, r_accLo} <= {w_sum, r_accLo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hi           <= '0;
            r_lo           <= '0;
            r_done         <= 1'b0;
            r_divZeroPulse <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_divZeroPulse <= 1'b0;
            if ((r_state == FIX) && !flush) begin
                r_hi           <= w_fixHi;
                r_lo           <= w_fixLo;
                r_done         <= 1'b1;
                r_divZeroPulse <= r_divZero;
            end else if (w_mthi) begin
                r_hi <= src_a;
            end else if (w_mtlo) begin
                r_lo <= src_a;
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_divZeroPulse;

endmodule
